// File: rtl/rsi_calc.sv
// rsi_calc: streaming RSI over the last N price deltas.
// Each accepted price updates a circular window of per-tick gains and losses
// and their running sums. Once the window is full, a 7-step restoring divider
// produces floor(100*SumG / (SumG+SumL)).
module rsi_calc #(
  parameter int unsigned N = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        price_valid,
  input  logic [31:0] price,
  output logic        price_ready,
  output logic [31:0] RSI,
  output logic        rsi_valid
);

  localparam int unsigned CW = $clog2(N + 1);  // count / sum growth bits
  localparam int unsigned SW = 32 + CW;        // gain/loss sum width
  localparam int unsigned WW = $clog2(N);      // window pointer width
  localparam int unsigned DW = SW + 1;         // denominator width
  localparam int unsigned NW = SW + 7;         // numerator / remainder width

  typedef enum logic [1:0] {IDLE, UPDATE, DIV, DONE} state_t;

  state_t          r_state;
  state_t          w_state_n;

  logic [31:0]     r_cur;
  logic [31:0]     r_prev;
  logic            r_have_prev;
  logic [31:0]     r_gbuf [N];
  logic [31:0]     r_lbuf [N];
  logic [SW-1:0]   r_sum_g;
  logic [SW-1:0]   r_sum_l;
  logic [WW-1:0]   r_wp;
  logic [CW-1:0]   r_count;
  logic [NW-1:0]   r_rem;
  logic [DW-1:0]   r_den;
  logic [6:0]      r_q;
  logic [2:0]      r_k;

  logic [31:0]     w_gain;
  logic [31:0]     w_loss;
  logic [SW-1:0]   w_sum_g_n;
  logic [SW-1:0]   w_sum_l_n;
  logic [CW-1:0]   w_count_n;
  logic            w_full;
  logic [NW-1:0]   w_trial;
  logic            w_fit;
  logic [6:0]      w_q_step;

  // Window update arithmetic and one restoring-divider step.
  always_comb begin
    w_gain    = (r_cur > r_prev) ? (r_cur - r_prev) : '0;
    w_loss    = (r_prev > r_cur) ? (r_prev - r_cur) : '0;
    w_sum_g_n = r_sum_g + SW'(w_gain) - SW'(r_gbuf[r_wp]);
    w_sum_l_n = r_sum_l + SW'(w_loss) - SW'(r_lbuf[r_wp]);
    w_count_n = (r_count == CW'(N)) ? r_count : r_count + 1'b1;
    w_full    = (w_count_n == CW'(N));
    w_trial   = NW'(r_den) << r_k;
    w_fit     = (r_rem >= w_trial);
    w_q_step  = r_q;
    w_q_step[r_k] = w_fit;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  // Next-state decode and handshake/strobe outputs.
  always_comb begin
    w_state_n   = r_state;
    price_ready = 1'b0;
    rsi_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        price_ready = 1'b1;
        if (price_valid) w_state_n = UPDATE;
      end
      UPDATE: w_state_n = (r_have_prev && w_full) ? DIV : IDLE;
      DIV:    if (r_k == 3'd0) w_state_n = DONE;
      DONE: begin
        rsi_valid = 1'b1;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
    if (rst) begin
      price_ready = 1'b0;
      rsi_valid   = 1'b0;
    end
  end

  // Datapath: price capture, window/sums update, divider iteration, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur       <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_sum_g     <= '0;
      r_sum_l     <= '0;
      r_wp        <= '0;
      r_count     <= '0;
      r_rem       <= '0;
      r_den       <= '0;
      r_q         <= '0;
      r_k         <= '0;
      RSI         <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_gbuf[i] <= '0;
        r_lbuf[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: if (price_valid) r_cur <= price;
        UPDATE: begin
          r_prev <= r_cur;
          if (!r_have_prev) begin
            r_have_prev <= 1'b1;
          end else begin
            r_sum_g      <= w_sum_g_n;
            r_sum_l      <= w_sum_l_n;
            r_gbuf[r_wp] <= w_gain;
            r_lbuf[r_wp] <= w_loss;
            r_wp         <= (r_wp == WW'(N - 1)) ? '0 : r_wp + 1'b1;
            r_count      <= w_count_n;
            r_rem        <= NW'(w_sum_g_n) * NW'(100);
            r_den        <= DW'(w_sum_g_n) + DW'(w_sum_l_n);
            r_q          <= '0;
            r_k          <= 3'd6;
          end
        end
        DIV: begin
          if (w_fit) r_rem <= r_rem - w_trial;
          r_q <= w_q_step;
          // Result is registered on the final divide step so RSI is already
          // valid during the DONE cycle alongside the strobe.
          if (r_k == 3'd0)
            RSI <= (r_den == '0) ? 32'd50 : {25'b0, w_q_step};
          else
            r_k <= r_k - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsi_calc.sv
// Directed bench for rsi_calc: N=4 instance for functional/handshake cases,
// N=64 instance for full-scale magnitude case.
module tb_rsi_calc;

  logic        clk;
  logic        rst;
  logic        a_valid, a_ready, a_rv;
  logic [31:0] a_price, a_rsi;
  logic        b_valid, b_ready, b_rv;
  logic [31:0] b_price, b_rsi;

  int n_checks = 0;
  int n_fail   = 0;

  rsi_calc #(.N(4)) u_dut_a (
    .clk(clk), .rst(rst), .price_valid(a_valid), .price(a_price),
    .price_ready(a_ready), .RSI(a_rsi), .rsi_valid(a_rv)
  );

  rsi_calc #(.N(64)) u_dut_b (
    .clk(clk), .rst(rst), .price_valid(b_valid), .price(b_price),
    .price_ready(b_ready), .RSI(b_rsi), .rsi_valid(b_rv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // rsi_valid must never be high on two consecutive cycles.
  logic prev_a_rv = 1'b0;
  logic prev_b_rv = 1'b0;
  always @(negedge clk) begin
    if (a_rv) check_eq("a_no_b2b", prev_a_rv, 0);
    if (b_rv) check_eq("b_no_b2b", prev_b_rv, 0);
    prev_a_rv = a_rv;
    prev_b_rv = b_rv;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic get_ready(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction

  function automatic logic get_rv(input bit sel);
    return sel ? b_rv : a_rv;
  endfunction

  function automatic logic [31:0] get_rsi(input bit sel);
    return sel ? b_rsi : a_rsi;
  endfunction

  // Price presented at handshake-test edge c.
  function automatic logic [31:0] hs_price(input int c);
    return (c % 4 == 0) ? 32'(1000 + 3 * c) : 32'(1000 - 2 * c);
  endfunction

  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0;
    a_price = '0;   b_price = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", a_ready, 0);
    check_eq("rst_rv", a_rv, 0);
    check_eq("rst_rsi", a_rsi, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", a_ready, 1);
  endtask

  // One price transfer; checks either warm-up return or 9-cycle result.
  task automatic push(input bit sel, input logic [31:0] p, input bit exp_out,
                      input logic [31:0] exp_rsi);
    int t, first, nstb, busy;
    logic [31:0] got;
    t = 0; first = 0; nstb = 0; busy = 0; got = '0;
    @(negedge clk);
    while (!get_ready(sel) && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30) begin
      check_eq("ready_timeout", 0, 1);
      return;
    end
    if (sel) begin b_valid = 1'b1; b_price = p; end
    else     begin a_valid = 1'b1; a_price = p; end
    @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_price = 32'hDEAD_BEEF; b_price = 32'hDEAD_BEEF;
    if (exp_out) begin
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (i <= 9 && get_ready(sel)) busy++;
        if (get_rv(sel)) begin
          nstb++;
          if (first == 0) begin first = i; got = get_rsi(sel); end
        end
        if (i == 10) check_eq("ready_after_done", get_ready(sel), 1);
      end
      check_eq("strobe_latency", first, 9);
      check_eq("strobe_count", nstb, 1);
      check_eq("rsi_value", got, exp_rsi);
      check_eq("busy_ready_low", busy, 0);
    end else begin
      for (int i = 1; i <= 2; i++) begin
        @(negedge clk);
        if (get_rv(sel)) nstb++;
      end
      check_eq("warm_no_strobe", nstb, 0);
      check_eq("warm_ready", get_ready(sel), 1);
    end
  endtask

  initial begin
    int xfer_c[$];
    int stb_c[$];
    logic [31:0] stb_v[$];
    int exp_x[8]   = '{0, 2, 4, 6, 8, 18, 28, 38};
    int exp_sc[4]  = '{17, 27, 37, 47};
    int exp_sv[4]  = '{65, 38, 65, 41};
    int nstb;

    do_reset();

    // Steady rise: all gains.
    push(0, 100, 0, 0); push(0, 101, 0, 0); push(0, 102, 0, 0);
    push(0, 103, 0, 0); push(0, 104, 1, 100);

    // Steady fall, then flat until window is all zeros.
    do_reset();
    push(0, 200, 0, 0); push(0, 190, 0, 0); push(0, 180, 0, 0);
    push(0, 170, 0, 0); push(0, 160, 1, 0);
    push(0, 160, 1, 0); push(0, 160, 1, 0); push(0, 160, 1, 0);
    push(0, 160, 1, 50);

    // Mixed deltas, then window wrap retiring the oldest gain.
    do_reset();
    push(0, 100, 0, 0); push(0, 104, 0, 0); push(0, 102, 0, 0);
    push(0, 105, 0, 0); push(0, 104, 1, 70);
    push(0, 110, 1, 75);

    // Valid held high with a new price every cycle.
    do_reset();
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (a_rv) begin stb_c.push_back(c); stb_v.push_back(a_rsi); end
      a_valid = 1'b1;
      a_price = hs_price(c);
      if (a_ready) xfer_c.push_back(c);
    end
    a_valid = 1'b0;
    check_eq("hs_xfer_count", xfer_c.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < xfer_c.size()) check_eq("hs_xfer_edge", xfer_c[i], exp_x[i]);
    check_eq("hs_strobe_count", stb_c.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < stb_c.size()) begin
        check_eq("hs_strobe_cycle", stb_c[i], exp_sc[i]);
        check_eq("hs_rsi", stb_v[i], exp_sv[i]);
      end

    // Reset asserted mid-divide aborts the result and clears the window.
    do_reset();
    push(0, 10, 0, 0); push(0, 11, 0, 0); push(0, 12, 0, 0); push(0, 13, 0, 0);
    @(negedge clk);
    a_valid = 1'b1; a_price = 14;
    @(posedge clk);
    #1 a_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    nstb = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) check_eq("abort_ready", a_ready, 1);
      if (a_rv) nstb++;
    end
    check_eq("abort_no_strobe", nstb, 0);
    check_eq("abort_rsi_zero", a_rsi, 0);
    push(0, 20, 0, 0); push(0, 21, 0, 0); push(0, 22, 0, 0);
    push(0, 23, 0, 0); push(0, 24, 1, 100);

    // N=64 full-scale alternating extremes.
    for (int i = 0; i < 65; i++)
      push(1, (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0, (i == 64), 50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
